// File: rtl/wb_multi_arbiter.sv
// Wishbone multi-master arbiter: one transaction at a time, round-robin or fixed
// priority grant, bus timeout with forced error and per-master cancel (flush).
module wb_multi_arbiter #(
    parameter int  NUM_MASTERS = 2,
    parameter int  ADDR_WIDTH  = 32,
    parameter int  DATA_WIDTH  = 32,
    parameter int  RR_MODE     = 1,
    parameter int  TIMEOUT     = 255,
    localparam int SEL_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
    input  logic [NUM_MASTERS-1:0]            m_flush,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [NUM_MASTERS-1:0]            m_stall,
    output logic                              wb_cyc_o,
    output logic                              wb_stb_o,
    output logic                              wb_we_o,
    output logic [ADDR_WIDTH-1:0]             wb_adr_o,
    output logic [DATA_WIDTH-1:0]             wb_dat_o,
    output logic [SEL_WIDTH-1:0]              wb_sel_o,
    input  logic [DATA_WIDTH-1:0]             wb_dat_i,
    input  logic                              wb_ack_i,
    input  logic                              wb_err_i
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, sel_idx, rr_ptr;
    logic [CW-1:0]   tmo_cnt;
    logic            cancel, cancel_now;
    logic            any_req, tmo_hit, bus_err, bus_exit;
    int              start;

    function automatic logic [GW-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
        return GW'(sum);
    endfunction

    // Search begins at rr_ptr in round-robin mode, at master 0 otherwise.
    always_comb begin
        start   = (RR_MODE != 0) ? int'(rr_ptr) : 0;
        sel_idx = '0;
        any_req = 1'b0;
        for (int off = 0; off < NUM_MASTERS; off++) begin
            if (!any_req && m_req[wrap_idx(start, off)]) begin
                sel_idx = wrap_idx(start, off);
                any_req = 1'b1;
            end
        end
    end

    // An ack arriving in the last allowed cycle still counts as a normal completion.
    assign tmo_hit    = (tmo_cnt == CW'(TIMEOUT - 1));
    assign bus_err    = wb_err_i | (tmo_hit & ~wb_ack_i);
    assign bus_exit   = wb_ack_i | bus_err;
    assign cancel_now = cancel | m_flush[grant];

    assign wb_cyc_o = (state == ST_BUS);
    assign wb_stb_o = (state == ST_BUS);
    assign m_stall  = m_req & ~m_ack;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req)  state_nxt = ST_BUS;
            ST_BUS:  if (bus_exit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            rr_ptr   <= '0;
            tmo_cnt  <= '0;
            cancel   <= 1'b0;
            m_ack    <= '0;
            m_err    <= '0;
            m_rdata  <= '0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
        end else begin
            m_ack <= '0;
            m_err <= '0;
            case (state)
                ST_IDLE: begin
                    cancel <= 1'b0;
                    if (any_req) begin
                        grant    <= sel_idx;
                        tmo_cnt  <= '0;
                        cancel   <= m_flush[sel_idx];
                        wb_we_o  <= m_we[sel_idx];
                        wb_adr_o <= m_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wb_dat_o <= m_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
                        wb_sel_o <= m_sel[sel_idx*SEL_WIDTH +: SEL_WIDTH];
                    end
                end
                ST_BUS: begin
                    if (tmo_cnt != CW'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
                    cancel <= cancel_now;
                    if (bus_exit) begin
                        rr_ptr <= (int'(grant) == NUM_MASTERS - 1) ? '0 : grant + 1'b1;
                        // A cancelled transaction finishes on the bus but stays invisible to its master.
                        if (!cancel_now) begin
                            m_ack[grant] <= 1'b1;
                            m_err[grant] <= bus_err;
                            m_rdata[grant*DATA_WIDTH +: DATA_WIDTH] <= bus_err ? '0 : wb_dat_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_multi_arbiter.sv
// Self-checking bench for wb_multi_arbiter: scoreboarded round-robin DUT with a
// scripted Wishbone slave, plus a fixed-priority DUT with an always-ack slave.
module tb_wb_multi_arbiter;
    localparam int TB_TIMEOUT = 4;
    localparam int M_ACK = 0, M_ERR = 1, M_NONE = 2, M_BOTH = 3;

    typedef struct {
        int          mst;
        logic        we;
        logic [31:0] adr, dat, rd, keep;
        logic [3:0]  sel;
        int          mode, delay, len;
        bit          flush, flush_other;
    } txn_t;

    typedef struct {
        int          mst;
        logic        err;
        logic [31:0] rd;
    } ack_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_req = '0, m_we = '0, m_flush = '0;
    logic [63:0] m_addr = '0, m_wdata = '0, m_rdata;
    logic [7:0]  m_sel = '0;
    logic [1:0]  m_ack, m_err, m_stall;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

    logic [1:0]  fp_req = '0;
    logic [63:0] fp_addr = '0, fp_rdata;
    logic [1:0]  fp_ack, fp_err, fp_stall;
    logic        fp_cyc, fp_stb, fp_we, fp_ack_i = 1'b0;
    logic [31:0] fp_adr, fp_dat;
    logic [3:0]  fp_sel;

    txn_t        mq0[$], mq1[$], bus_q[$];
    ack_t        ack_q[$];
    logic [31:0] fp_q[$];
    logic [31:0] model_rd [2];
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_multi_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                       .RR_MODE(1), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_sel(m_sel), .m_flush(m_flush), .m_rdata(m_rdata),
        .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i));

    wb_multi_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                       .RR_MODE(0), .TIMEOUT(255)) dut_fp (
        .clk(clk), .rst(rst), .m_req(fp_req), .m_we(2'b00), .m_addr(fp_addr),
        .m_wdata(64'h0), .m_sel(8'hFF), .m_flush(2'b00), .m_rdata(fp_rdata),
        .m_ack(fp_ack), .m_err(fp_err), .m_stall(fp_stall), .wb_cyc_o(fp_cyc),
        .wb_stb_o(fp_stb), .wb_we_o(fp_we), .wb_adr_o(fp_adr),
        .wb_dat_o(fp_dat), .wb_sel_o(fp_sel), .wb_dat_i(32'h0000F00D),
        .wb_ack_i(fp_ack_i), .wb_err_i(1'b0));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic txn_t mk(input int mst, input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel,
                                input int mode, input int delay, input logic [31:0] rd);
        txn_t t;
        t.mst = mst; t.we = we; t.adr = adr; t.dat = dat; t.sel = sel;
        t.mode = mode; t.delay = delay; t.rd = rd; t.keep = '0;
        t.len = (mode == M_NONE) ? TB_TIMEOUT : delay;
        t.flush = 1'b0; t.flush_other = 1'b0;
        return t;
    endfunction

    task automatic stim(input txn_t t);
        if (t.mst == 0) mq0.push_back(t);
        else            mq1.push_back(t);
    endtask

    // Expectations are pushed in the order the bench expects grants to occur.
    task automatic expect_txn(input txn_t t, input bit bus_only);
        ack_t ea;
        if (t.we) t.rd = model_rd[t.mst];
        t.keep = model_rd[t.mst];
        bus_q.push_back(t);
        if (!t.flush && !bus_only) begin
            ea.mst = t.mst;
            ea.err = (t.mode != M_ACK);
            ea.rd  = ea.err ? 32'h0 : t.rd;
            model_rd[t.mst] = ea.rd;
            ack_q.push_back(ea);
        end
    endtask

    task automatic send(input txn_t t);
        stim(t);
        expect_txn(t, 1'b0);
    endtask

    task automatic clear_q();
        mq0.delete(); mq1.delete(); bus_q.delete(); ack_q.delete();
        model_rd[0] = '0; model_rd[1] = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((mq0.size() > 0 || mq1.size() > 0 || bus_q.size() > 0 ||
                ack_q.size() > 0 || wb_cyc_o) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_time", n < budget, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_q();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_ack", m_ack, 0);
        check("rst_err", m_err, 0);
        check("rst_rdata", m_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Master drivers, scripted slave and scoreboard monitor, all at the falling edge.
    initial begin : bfm
        txn_t cur;
        ack_t ea;
        int   bus_cnt;
        bus_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus_cnt = 0; m_req = '0; m_flush = '0;
                wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (m_ack[i] || m_err[i]) begin
                        check("ack_with_err", m_ack[i], 1);
                        check("stall_on_ack", m_stall[i], 0);
                        check("ack_expected", ack_q.size() > 0, 1);
                        if (ack_q.size() > 0) begin
                            ea = ack_q.pop_front();
                            check("ack_master", 64'(i), 64'(ea.mst));
                            check("ack_err", m_err[i], ea.err);
                            check("ack_rdata", m_rdata[i*32 +: 32], ea.rd);
                        end
                        if (i == 0 && mq0.size() > 0) mq0.delete(0);
                        if (i == 1 && mq1.size() > 0) mq1.delete(0);
                    end
                end
                m_flush = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
                if (wb_cyc_o) begin
                    bus_cnt++;
                    if (bus_cnt == 1) begin
                        check("bus_expected", bus_q.size() > 0, 1);
                        if (bus_q.size() > 0) cur = bus_q.pop_front();
                    end
                    check("bus_stb", wb_stb_o, 1);
                    check("bus_stall", m_stall, m_req);
                    check("bus_we", wb_we_o, cur.we);
                    check("bus_adr", wb_adr_o, cur.adr);
                    check("bus_dat", wb_dat_o, cur.dat);
                    check("bus_sel", wb_sel_o, cur.sel);
                    wb_dat_i = cur.rd;
                    if (bus_cnt == cur.delay && cur.mode != M_NONE) begin
                        wb_ack_i = (cur.mode == M_ACK || cur.mode == M_BOTH);
                        wb_err_i = (cur.mode == M_ERR || cur.mode == M_BOTH);
                    end
                    if (bus_cnt == 1 && cur.flush) begin
                        m_flush[cur.mst] = 1'b1;
                        if (cur.mst == 0 && mq0.size() > 0) mq0.delete(0);
                        if (cur.mst == 1 && mq1.size() > 0) mq1.delete(0);
                    end
                    if (bus_cnt == 1 && cur.flush_other) m_flush[1 - cur.mst] = 1'b1;
                end else if (bus_cnt > 0) begin
                    check("bus_len", 64'(bus_cnt), 64'(cur.len));
                    if (cur.flush) begin
                        check("flush_no_ack", m_ack, 0);
                        check("flush_rdata_kept", m_rdata[cur.mst*32 +: 32], cur.keep);
                    end else begin
                        check("ack_latency", m_ack[cur.mst], 1);
                    end
                    bus_cnt = 0;
                end
                if (mq0.size() > 0) begin
                    m_req[0] = 1'b1; m_we[0] = mq0[0].we; m_addr[31:0] = mq0[0].adr;
                    m_wdata[31:0] = mq0[0].dat; m_sel[3:0] = mq0[0].sel;
                end else m_req[0] = 1'b0;
                if (mq1.size() > 0) begin
                    m_req[1] = 1'b1; m_we[1] = mq1[0].we; m_addr[63:32] = mq1[0].adr;
                    m_wdata[63:32] = mq1[0].dat; m_sel[7:4] = mq1[0].sel;
                end else m_req[1] = 1'b0;
            end
        end
    end

    initial begin : fp_slave
        forever begin
            @(negedge clk);
            fp_ack_i = fp_cyc;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        txn_t        t;
        int          seen, n, w;
        logic [31:0] want_adr;
        model_rd[0] = '0; model_rd[1] = '0;
        do_reset();

        // Single read, ack in second BUS cycle.
        send(mk(0, 1'b0, 32'h100, 32'h0, 4'hF, M_ACK, 2, 32'hDEADBEEF));
        wait_idle(100);
        // Write on master 1, held stable through BUS.
        send(mk(1, 1'b1, 32'h200, 32'h1234, 4'b0011, M_ACK, 3, 32'h0));
        wait_idle(100);

        // Round-robin with both requests held.
        do_reset();
        stim(mk(0, 1'b0, 32'h300, 32'h0, 4'hF, M_ACK, 1, 32'hA0));
        stim(mk(0, 1'b0, 32'h304, 32'h0, 4'hF, M_ACK, 1, 32'hA1));
        stim(mk(1, 1'b0, 32'h380, 32'h0, 4'hF, M_ACK, 1, 32'hB0));
        stim(mk(1, 1'b0, 32'h384, 32'h0, 4'hF, M_ACK, 1, 32'hB1));
        expect_txn(mk(0, 1'b0, 32'h300, 32'h0, 4'hF, M_ACK, 1, 32'hA0), 1'b0);
        expect_txn(mk(1, 1'b0, 32'h380, 32'h0, 4'hF, M_ACK, 1, 32'hB0), 1'b0);
        expect_txn(mk(0, 1'b0, 32'h304, 32'h0, 4'hF, M_ACK, 1, 32'hA1), 1'b0);
        expect_txn(mk(1, 1'b0, 32'h384, 32'h0, 4'hF, M_ACK, 1, 32'hB1), 1'b0);
        wait_idle(200);

        // Errors: slave error, ack+err together, then timeout.
        send(mk(0, 1'b0, 32'h140, 32'h0, 4'hF, M_ERR, 2, 32'h999));
        wait_idle(100);
        send(mk(1, 1'b0, 32'h180, 32'h0, 4'hF, M_BOTH, 1, 32'h777));
        wait_idle(100);
        send(mk(1, 1'b0, 32'h1C0, 32'h0, 4'hF, M_ACK, 1, 32'h55AA));
        wait_idle(100);
        send(mk(1, 1'b0, 32'h1E0, 32'h0, 4'hF, M_NONE, 1, 32'h1234));
        wait_idle(100);

        // Flush of an idle master is ignored; flush of the granted master cancels.
        t = mk(0, 1'b0, 32'h240, 32'h0, 4'hF, M_ACK, 2, 32'hC0DE);
        t.flush_other = 1'b1;
        send(t);
        wait_idle(100);
        t = mk(0, 1'b0, 32'h280, 32'h0, 4'hF, M_ACK, 3, 32'hBAD);
        t.flush = 1'b1;
        send(t);
        send(mk(0, 1'b0, 32'h2C0, 32'h0, 4'hF, M_ACK, 1, 32'hC0FFEE));
        wait_idle(200);

        // Reset in the middle of BUS: cyc drops, no ack, round-robin pointer back to 0.
        send(mk(0, 1'b0, 32'h400, 32'h0, 4'hF, M_ACK, 1, 32'h11));
        wait_idle(100);
        t = mk(1, 1'b0, 32'h500, 32'h0, 4'hF, M_ACK, 4, 32'h22);
        stim(t);
        expect_txn(t, 1'b1);
        seen = 0; n = 0;
        while (seen < 2 && n < 50) begin
            @(negedge clk);
            n++;
            seen = wb_cyc_o ? seen + 1 : 0;
        end
        check("mid_bus_reached", 64'(seen), 2);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        clear_q();
        @(negedge clk);
        check("rst_mid_cyc", wb_cyc_o, 0);
        check("rst_mid_ack", m_ack, 0);
        check("rst_mid_rdata", m_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        stim(mk(0, 1'b0, 32'h600, 32'h0, 4'hF, M_ACK, 1, 32'h66));
        stim(mk(1, 1'b0, 32'h700, 32'h0, 4'hF, M_ACK, 1, 32'h77));
        expect_txn(mk(0, 1'b0, 32'h600, 32'h0, 4'hF, M_ACK, 1, 32'h66), 1'b0);
        expect_txn(mk(1, 1'b0, 32'h700, 32'h0, 4'hF, M_ACK, 1, 32'h77), 1'b0);
        wait_idle(200);

        // Fixed priority: both held, master 0 wins every time.
        fp_addr = {32'h20, 32'h10};
        fp_req  = 2'b11;
        repeat (4) fp_q.push_back(32'h10);
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!fp_cyc && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("fp_grant_seen", w < 20, 1);
            want_adr = fp_q.pop_front();
            check("fp_grant_adr", fp_adr, want_adr);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (fp_ack == 2'b00 && w < 5);
            check("fp_ack", fp_ack, 2'b01);
        end
        check("fp_rdata", fp_rdata[31:0], 32'h0000F00D);
        fp_req = 2'b00;

        check("ack_q_empty", 64'(ack_q.size()), 0);
        check("bus_q_empty", 64'(bus_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
